// File: rtl/mpadder_pkg.sv
// Shared types for the multi-precision adder arbiter: widths, FSM states,
// owner ids and the latency-counter width helper.
package mpadder_pkg;

    localparam int WIDTH_DEF   = 1027;
    localparam int ADD_LAT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_e;

    // Counter must hold 0..ADD_LAT; clamp so an illegal latency still elaborates
    // far enough to reach the explicit error in the top.
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mpadder_arbiter_if.sv
// Requester / response / adder bundle for mpadder_arbiter.
// slave: arbiter side; master: requesters + adder side.
interface mpadder_arbiter_if
    import mpadder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    logic [1:0]       rsp_valid;
    logic [WIDTH:0]   rsp_data;
    logic             add_start;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_sub;
    logic [WIDTH:0]   add_result;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  add_result,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data,
        output add_start, add_a, add_b, add_sub,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output add_result,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data,
        input  add_start, add_a, add_b, add_sub,
        input  busy
    );

endinterface

// File: rtl/mpadder_arb_grant.sv
// 2-way grant: valid[1:0] -> one-hot grant. MPADDER_ARB_RR_EN selects
// round-robin on ties (via last_grant); otherwise port 0 wins ties.
module mpadder_arb_grant
    import mpadder_pkg::*;
(
`ifdef MPADDER_ARB_RR_EN
    input  owner_e     last_grant,
`endif
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
`ifdef MPADDER_ARB_RR_EN
            2'b11: grant = (last_grant == OWN_P1) ? 2'b01 : 2'b10;
`else
            2'b11: grant = 2'b01;
`endif
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mpadder_arbiter.sv
// Shares one fixed-latency WIDTH-bit add/sub unit between two requesters.
// Ports: clk, reset (async, active high), bus (slave modport of
// mpadder_arbiter_if: req0/req1 handshakes, rsp, adder launch/result, busy).
// Optional macro MPADDER_ARB_RR_EN: round-robin tie-break instead of port 0.
module mpadder_arbiter
    import mpadder_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF
)(
    input  logic                clk,
    input  logic                reset,
    mpadder_arbiter_if.slave    bus
);

    localparam int CW = cnt_width(ADD_LAT);

    if (ADD_LAT < 1) begin : g_bad_lat
        $error("mpadder_arbiter: ADD_LAT must be >= 1");
    end

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_sub_q, add_sub_d;
    logic             add_start_q, add_start_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH:0]   rsp_data_q, rsp_data_d;

    logic [1:0]       grant;
    logic [1:0]       ready;
    logic             idle;
    logic             accept;

`ifdef MPADDER_ARB_RR_EN
    owner_e           last_grant_q, last_grant_d;

    mpadder_arb_grant u_grant (
        .last_grant (last_grant_q),
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .grant      (grant)
    );
`else
    mpadder_arb_grant u_grant (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .grant      (grant)
    );
`endif

    assign idle   = (state_q == ST_IDLE);
    assign ready  = idle ? grant : 2'b00;
    assign accept = |ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_sub_d   = add_sub_q;
        add_start_d = 1'b0;
        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
`ifdef MPADDER_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d     = ready[1] ? OWN_P1 : OWN_P0;
                    add_a_d     = ready[1] ? bus.req1_a   : bus.req0_a;
                    add_b_d     = ready[1] ? bus.req1_b   : bus.req0_b;
                    add_sub_d   = ready[1] ? bus.req1_sub : bus.req0_sub;
                    // Registered so the pulse lands in the LAUNCH cycle.
                    add_start_d = 1'b1;
                    state_d     = ST_LAUNCH;
`ifdef MPADDER_ARB_RR_EN
                    last_grant_d = ready[1] ? OWN_P1 : OWN_P0;
`endif
                end
            end
            ST_LAUNCH: begin
                // Always via WAIT: the result is sampled ADD_LAT cycles
                // after add_start, which for ADD_LAT==1 is the WAIT cycle.
                cnt_d   = CW'(ADD_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = bus.add_result;
                    rsp_valid_d = (owner_q == OWN_P1) ? 2'b10 : 2'b01;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_P0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_sub_q   <= 1'b0;
            add_start_q <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
`ifdef MPADDER_ARB_RR_EN
            last_grant_q <= OWN_P1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_sub_q   <= add_sub_d;
            add_start_q <= add_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef MPADDER_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.add_start  = add_start_q;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.add_sub    = add_sub_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = ~idle | accept;

endmodule
